lsuc_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the local IO bus, selected by `uart_cs` (CPU window 0xE000_0000).
- Sits directly downstream of the IO bus controller: consumes `addr`/`rnw`/`req`/`wr_data`/`cs` and returns `rd_data`/`rdy`.
- Contains 16-entry TX and RX FIFOs, a programmable baud divisor and sticky error flags.

---
 rtl/lsuc_uart.sv | 236 +++++++++++++++++++++++
 tb/tb_lsuc_uart.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsuc_uart.sv
// Memory-mapped 8N1 UART: 16-entry TX/RX FIFOs, programmable baud divisor, sticky error flags.
// Bus accesses complete with a one-cycle rdy pulse; rd_data is registered alongside it.
module lsuc_uart #(
   parameter logic [15:0] DIVISOR_RST     = 16'd867,
   parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic [7:0] addr,
   input  logic       rnw,
   input  logic       req,
   input  logic       cs,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       rdy,
   output logic       tx,
   input  logic       rx
);

   localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
   localparam int unsigned AW    = FIFO_DEPTH_LOG2;

   typedef logic [AW:0] ptr_t;
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic       acc, wr, rd;
   logic [1:0] sel;
   logic       unused_addr;

   assign acc         = req & cs;
   assign wr          = acc & ~rnw;
   assign rd          = acc & rnw;
   assign sel         = addr[3:2];
   assign unused_addr = ^{addr[7:4], addr[1:0]};

   logic [7:0]  tx_mem_q [Depth];
   logic [7:0]  rx_mem_q [Depth];
   ptr_t        tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
   logic        tx_empty, tx_full, rx_empty, rx_full;
   logic        tx_push, tx_pop, rx_push, rx_pop;
   logic [15:0] div_q;
   logic        tx_ovf_q, frame_err_q, rx_ovr_q;
   logic        tx_ovf_set, frame_set, rx_ovr_set;
   logic [2:0]  w1c;
   logic        rdy_q;
   logic [7:0]  rd_data_q, rd_val, status;

   state_e      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d, rx_half;
   logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
   logic [1:0]  rx_sync_q;
   logic        rx_prev_q, rx_s;

   // Pointers carry one extra wrap bit so full and empty differ.
   assign tx_empty = tx_wptr_q == tx_rptr_q;
   assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
   assign rx_empty = rx_wptr_q == rx_rptr_q;
   assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

   assign tx_push    = wr && (sel == 2'd0) && (!tx_full || tx_pop);
   assign tx_ovf_set = wr && (sel == 2'd0) && tx_full && !tx_pop;
   assign rx_pop     = rd && (sel == 2'd0) && !rx_empty;
   assign w1c        = (wr && (sel == 2'd1)) ? wr_data[7:5] : 3'b000;

   assign status = {tx_ovf_q, frame_err_q, rx_ovr_q, tx_state_q != StIdle,
                    tx_full, tx_empty, rx_full, !rx_empty};

   always_comb begin
      rd_val = 8'h00;
      unique case (sel)
         2'd0: rd_val = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q[AW-1:0]];
         2'd1: rd_val = status;
         2'd2: rd_val = div_q[7:0];
         2'd3: rd_val = div_q[15:8];
         default: rd_val = 8'h00;
      endcase
   end

   assign rd_data = rd_data_q;
   assign rdy     = rdy_q;
   assign tx      = (tx_state_q == StStart) ? 1'b0 :
                    (tx_state_q == StData)  ? tx_sh_q[0] : 1'b1;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      unique case (tx_state_q)
         StIdle: begin
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_mem_q[tx_rptr_q[AW-1:0]];
               tx_cnt_d   = div_q;
               tx_state_d = StStart;
            end
         end
         StStart: begin
            if (tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
            else begin
               tx_cnt_d   = div_q;
               tx_bit_d   = 3'd0;
               tx_state_d = StData;
            end
         end
         StData: begin
            if (tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
            else begin
               tx_cnt_d = div_q;
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = StStop;
            end
         end
         StStop: begin
            if (tx_cnt_q != 16'd0) tx_cnt_d = tx_cnt_q - 16'd1;
            else if (!tx_empty) begin
               // Chain straight into the next START with no idle gap.
               tx_pop     = 1'b1;
               tx_sh_d    = tx_mem_q[tx_rptr_q[AW-1:0]];
               tx_cnt_d   = div_q;
               tx_state_d = StStart;
            end else begin
               tx_state_d = StIdle;
            end
         end
         default: tx_state_d = StIdle;
      endcase
   end

   // (divisor+1)>>1 clocks in START, expressed as a count-down load.
   assign rx_half = {1'b0, div_q[15:1]} + {15'd0, div_q[0]} - 16'd1;
   assign rx_s    = rx_sync_q[1];

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_push    = 1'b0;
      rx_ovr_set = 1'b0;
      frame_set  = 1'b0;
      unique case (rx_state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s) begin
               rx_cnt_d   = rx_half;
               rx_state_d = StStart;
            end
         end
         StStart: begin
            if (rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
            else if (rx_s) rx_state_d = StIdle;
            else begin
               rx_cnt_d   = div_q;
               rx_bit_d   = 3'd0;
               rx_state_d = StData;
            end
         end
         StData: begin
            if (rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
            else begin
               rx_cnt_d = div_q;
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = StStop;
            end
         end
         StStop: begin
            if (rx_cnt_q != 16'd0) rx_cnt_d = rx_cnt_q - 16'd1;
            else begin
               rx_state_d = StIdle;
               if (!rx_s) frame_set = 1'b1;
               else if (!rx_full || rx_pop) rx_push = 1'b1;
               else rx_ovr_set = 1'b1;
            end
         end
         default: rx_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= wr_data;
      if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= rx_sh_q;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rdy_q       <= 1'b0;
         rd_data_q   <= 8'h00;
         div_q       <= DIVISOR_RST;
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
         tx_ovf_q    <= 1'b0;
         frame_err_q <= 1'b0;
         rx_ovr_q    <= 1'b0;
         tx_state_q  <= StIdle;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_sh_q     <= '0;
         rx_state_q  <= StIdle;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_sh_q     <= '0;
         rx_sync_q   <= 2'b11;
         rx_prev_q   <= 1'b1;
      end else begin
         rdy_q <= acc;
         if (rd) rd_data_q <= rd_val;
         if (wr && (sel == 2'd2)) div_q[7:0]  <= wr_data;
         if (wr && (sel == 2'd3)) div_q[15:8] <= wr_data;
         if (tx_push) tx_wptr_q <= tx_wptr_q + ptr_t'(1);
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + ptr_t'(1);
         if (rx_push) rx_wptr_q <= rx_wptr_q + ptr_t'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + ptr_t'(1);
         // Set wins over a same-cycle W1C.
         tx_ovf_q    <= (tx_ovf_q & ~w1c[2]) | tx_ovf_set;
         frame_err_q <= (frame_err_q & ~w1c[1]) | frame_set;
         rx_ovr_q    <= (rx_ovr_q & ~w1c[0]) | rx_ovr_set;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_sh_q     <= tx_sh_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_sh_q     <= rx_sh_d;
         rx_sync_q   <= {rx_sync_q[0], rx};
         rx_prev_q   <= rx_sync_q[1];
      end
   end

endmodule

// File: tb/tb_lsuc_uart.sv
// Self-checking bench for lsuc_uart: random bytes and divisors against a byte-level
// serial model (queues of expected bytes, bit waveforms built from 8N1 framing rules).
module tb_lsuc_uart;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [7:0] addr = 8'h00;
   logic       rnw = 1'b1;
   logic       req = 1'b0;
   logic       cs = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       rdy;
   logic       tx;
   logic       rx;
   logic       loopback = 1'b0;
   logic       rx_drv = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign rx = loopback ? tx : rx_drv;

   lsuc_uart dut (
      .clk     (clk),
      .reset_  (reset_),
      .addr    (addr),
      .rnw     (rnw),
      .req     (req),
      .cs      (cs),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .rdy     (rdy),
      .tx      (tx),
      .rx      (rx)
   );

   // Ignored address bits are randomised to exercise aliasing.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      addr = {4'($urandom), a[3:2], 2'($urandom)};
      wr_data = d; rnw = 1'b0; req = 1'b1; cs = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; cs = 1'b0; rnw = 1'b1;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic ok);
      @(negedge clk);
      addr = {4'($urandom), a[3:2], 2'($urandom)};
      rnw = 1'b1; req = 1'b1; cs = 1'b1;
      @(posedge clk); #1;
      d = rd_data; ok = rdy;
      req = 1'b0; cs = 1'b0;
   endtask

   task automatic set_div(input logic [15:0] v);
      bus_write(8'h08, v[7:0]);
      bus_write(8'h0C, v[15:8]);
   endtask

   // Drives one 8N1 frame on rx_drv; caller aligns to a negedge.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int bc);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int s = 0; s < 10; s++) begin
         rx_drv = bits[s];
         repeat (bc) @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [7:0] d;
      logic       ok;
      reset_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || rdy !== 1'b0 || rd_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: tx=%b rdy=%b rd_data=%02h, expected 1 0 00", tx, rdy, rd_data);
      end
      @(negedge clk) reset_ = 1'b1;
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h04 || ok !== 1'b1) begin
         errors++;
         $display("FAIL reset_status: got %02h rdy=%b, expected 04 rdy=1", d, ok);
      end
      @(posedge clk); #1;
      checks++;
      if (rdy !== 1'b0 || rd_data !== 8'h04) begin
         errors++;
         $display("FAIL rdy_single_pulse: rdy=%b rd_data=%02h, expected 0 04", rdy, rd_data);
      end
      bus_read(8'h08, d, ok);
      checks++;
      if (d !== 8'h63 || ok !== 1'b1) begin
         errors++;
         $display("FAIL reset_div_lo: got %02h rdy=%b, expected 63 rdy=1", d, ok);
      end
      bus_read(8'h0C, d, ok);
      checks++;
      if (d !== 8'h03 || ok !== 1'b1) begin
         errors++;
         $display("FAIL reset_div_hi: got %02h rdy=%b, expected 03 rdy=1", d, ok);
      end
      @(negedge clk);
      addr = 8'h04; rnw = 1'b1; req = 1'b1; cs = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL cs_low_ignored: rdy=%b, expected 0", rdy);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] x;
      x = 8'($urandom);
      @(negedge clk);
      addr = 8'h08; wr_data = x; rnw = 1'b0; req = 1'b1; cs = 1'b1;
      @(negedge clk);
      addr = 8'h08; rnw = 1'b1;
      @(posedge clk); #1;
      req = 1'b0; cs = 1'b0;
      checks++;
      if (rdy !== 1'b1 || rd_data !== x) begin
         errors++;
         $display("FAIL back_to_back: rdy=%b rd_data=%02h, expected 1 %02h", rdy, rd_data, x);
      end
      @(posedge clk); #1;
      checks++;
      if (rdy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_rdy_drop: rdy=%b, expected 0", rdy);
      end
   endtask

   task automatic test_div;
      logic [15:0] v;
      logic [7:0]  lo, hi;
      logic        ok;
      for (int i = 0; i < 3; i++) begin
         v = 16'($urandom_range(3, 16'hFFFF));
         set_div(v);
         bus_read(8'h08, lo, ok);
         bus_read(8'h0C, hi, ok);
         checks++;
         if ({hi, lo} !== v) begin
            errors++;
            $display("FAIL div_readback: got %04h, expected %04h", {hi, lo}, v);
         end
      end
   endtask

   task automatic test_tx_frame;
      logic [7:0] bytes [3];
      logic [7:0] b, d;
      logic       ok, found, exp_bit;
      int         bad, first_bad;
      bytes[0] = 8'hA5;
      bytes[1] = 8'($urandom);
      bytes[2] = 8'($urandom);
      set_div(16'd3);
      for (int f = 0; f < 3; f++) begin
         b = bytes[f];
         bus_write(8'h00, b);
         found = 1'b0;
         for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (tx === 1'b0) found = 1'b1;
         end
         checks++;
         if (!found) begin
            errors++;
            $display("FAIL tx_start_timeout: no start bit for byte %02h", b);
         end else begin
            bad = 0;
            first_bad = -1;
            for (int k = 1; k < 40; k++) begin
               @(posedge clk); #1;
               exp_bit = (k / 4 == 0) ? 1'b0 : (k / 4 == 9) ? 1'b1 : b[k / 4 - 1];
               if (tx !== exp_bit) begin
                  bad++;
                  if (first_bad < 0) first_bad = k;
               end
            end
            if (bad != 0) begin
               errors++;
               $display("FAIL tx_waveform: byte %02h had %0d wrong clocks (first at %0d), expected 0",
                        b, bad, first_bad);
            end
         end
         repeat (2) @(posedge clk);
         bus_read(8'h04, d, ok);
         checks++;
         if (d !== 8'h04) begin
            errors++;
            $display("FAIL tx_idle_status: got %02h, expected 04", d);
         end
      end
   endtask

   task automatic test_loopback;
      logic [7:0]  q[$];
      logic [7:0]  d, e;
      logic        ok;
      logic [15:0] div;
      int          n;
      loopback = 1'b1;
      for (int r = 0; r < 2; r++) begin
         q.delete();
         if (r == 0) begin
            div = 16'd3;
            q.push_back(8'h3C);
            q.push_back(8'hC3);
         end else begin
            div = 16'($urandom_range(3, 9));
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         end
         set_div(div);
         foreach (q[i]) bus_write(8'h00, q[i]);
         repeat ((q.size() + 1) * 10 * (int'(div) + 1) + 20) @(posedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            bus_read(8'h00, d, ok);
            checks++;
            if (d !== e || ok !== 1'b1) begin
               errors++;
               $display("FAIL loopback_data: got %02h rdy=%b, expected %02h (div %0d)", d, ok, e, div);
            end
         end
         bus_read(8'h00, d, ok);
         checks++;
         if (d !== 8'h00) begin
            errors++;
            $display("FAIL loopback_empty_read: got %02h, expected 00", d);
         end
         bus_read(8'h04, d, ok);
         checks++;
         if (d !== 8'h04) begin
            errors++;
            $display("FAIL loopback_status: got %02h, expected 04", d);
         end
      end
      loopback = 1'b0;
   endtask

   task automatic test_frame_err;
      logic [7:0] d;
      logic       ok;
      set_div(16'd3);
      @(negedge clk);
      send_frame(8'($urandom), 1'b0, 4);
      rx_drv = 1'b1;
      repeat (20) @(posedge clk);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h44) begin
         errors++;
         $display("FAIL frame_err_status: got %02h, expected 44", d);
      end
      bus_write(8'h04, 8'h40);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h04) begin
         errors++;
         $display("FAIL frame_err_w1c: got %02h, expected 04", d);
      end
      bus_read(8'h00, d, ok);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL frame_err_no_push: got %02h, expected 00", d);
      end
   endtask

   task automatic test_rx_overrun;
      logic [7:0] q[$];
      logic [7:0] d, e;
      logic       ok;
      int         bad;
      set_div(16'd3);
      for (int i = 0; i < 17; i++) q.push_back(8'($urandom));
      @(negedge clk);
      foreach (q[i]) send_frame(q[i], 1'b1, 4);
      rx_drv = 1'b1;
      repeat (20) @(posedge clk);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h27) begin
         errors++;
         $display("FAIL rx_overrun_status: got %02h, expected 27", d);
      end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         e = q.pop_front();
         bus_read(8'h00, d, ok);
         if (d !== e) begin
            bad++;
            $display("FAIL rx_overrun_data[%0d]: got %02h, expected %02h", i, d, e);
         end
      end
      checks++;
      if (bad != 0) errors++;
      bus_read(8'h00, d, ok);
      checks++;
      if (d !== 8'h00) begin
         errors++;
         $display("FAIL rx_overrun_dropped: got %02h, expected 00", d);
      end
      bus_write(8'h04, 8'h20);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h04) begin
         errors++;
         $display("FAIL rx_overrun_w1c: got %02h, expected 04", d);
      end
   endtask

   task automatic test_glitch;
      logic [7:0] d;
      logic       ok;
      set_div(16'd3);
      @(negedge clk) rx_drv = 1'b0;
      @(negedge clk) rx_drv = 1'b1;
      repeat (40) @(posedge clk);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h04) begin
         errors++;
         $display("FAIL rx_glitch_status: got %02h, expected 04", d);
      end
   endtask

   task automatic test_tx_overflow;
      logic [7:0] d;
      logic       ok;
      set_div(16'd1000);
      bus_write(8'h00, 8'($urandom));
      repeat (5) @(posedge clk);
      for (int i = 0; i < 17; i++) bus_write(8'h00, 8'($urandom));
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h98) begin
         errors++;
         $display("FAIL tx_overflow_status: got %02h, expected 98", d);
      end
      bus_write(8'h04, 8'h80);
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h18) begin
         errors++;
         $display("FAIL tx_ovf_w1c: got %02h, expected 18", d);
      end
   endtask

   // Relies on test_tx_overflow leaving the transmitter inside a long start bit.
   task automatic test_reset_mid_frame;
      logic [7:0] d, hi;
      logic       ok;
      #1;
      checks++;
      if (tx !== 1'b0) begin
         errors++;
         $display("FAIL mid_frame_precondition: tx=%b, expected 0", tx);
      end
      @(negedge clk) reset_ = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_immediate: tx=%b, expected 1", tx);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset_ = 1'b1;
      bus_read(8'h04, d, ok);
      checks++;
      if (d !== 8'h04) begin
         errors++;
         $display("FAIL reset_mid_status: got %02h, expected 04", d);
      end
      bus_read(8'h08, d, ok);
      bus_read(8'h0C, hi, ok);
      checks++;
      if ({hi, d} !== 16'h0363) begin
         errors++;
         $display("FAIL reset_mid_div: got %04h, expected 0363", {hi, d});
      end
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1) begin
         errors++;
         $display("FAIL reset_tx_fifo_empty: tx=%b, expected 1", tx);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_div();
      test_tx_frame();
      test_loopback();
      test_frame_err();
      test_rx_overrun();
      test_glitch();
      test_tx_overflow();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
